// File: rtl/conv_layer_sequencer.sv
// Steps a shared conv1d engine through a programmable layer list for one OFDM frame.
// Each layer gets one ISSUE cycle (start pulse) and then RUN until eng_done; a watchdog or abort forces the exit.
module conv_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int WADDR_W    = 12,
  parameter int BADDR_W    = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [$clog2(NUM_LAYERS)-1:0]     cfg_addr,
  input  logic [WADDR_W-1:0]                cfg_wbase,
  input  logic [BADDR_W-1:0]                cfg_bbase,
  input  logic                              cfg_act,
  input  logic                              cfg_nl_we,
  input  logic [$clog2(NUM_LAYERS+1)-1:0]   cfg_nl,
  input  logic                              start,
  input  logic                              abort,
  output logic                              eng_start,
  input  logic                              eng_busy,
  input  logic                              eng_done,
  output logic [$clog2(NUM_LAYERS)-1:0]     layer_idx,
  output logic [WADDR_W-1:0]                w_base,
  output logic [BADDR_W-1:0]                b_base,
  output logic                              act_en,
  output logic                              rd_buf_sel,
  output logic                              wr_buf_sel,
  output logic                              result_buf,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err
);
  localparam int LW = $clog2(NUM_LAYERS);
  localparam int CW = $clog2(NUM_LAYERS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]         state;
  logic [WADDR_W-1:0] wtab [NUM_LAYERS];
  logic [BADDR_W-1:0] btab [NUM_LAYERS];
  logic               atab [NUM_LAYERS];
  logic [CW-1:0]      count;
  logic [TW-1:0]      wdog;

  logic [LW-1:0] idx_nxt;
  logic          last_layer;
  logic [CW-1:0] nl_clamped;
  logic [TW-1:0] wdog_inc;
  logic          timeout_hit;

  always_comb begin
    idx_nxt     = layer_idx + LW'(1);
    last_layer  = (CW'(layer_idx) + CW'(1)) >= count;
    nl_clamped  = (cfg_nl > CW'(NUM_LAYERS)) ? CW'(NUM_LAYERS) : cfg_nl;
    wdog_inc    = wdog + TW'(1);
    timeout_hit = (wdog_inc == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      count       <= '0;
      wdog        <= '0;
      eng_start   <= 1'b0;
      layer_idx   <= '0;
      w_base      <= '0;
      b_base      <= '0;
      act_en      <= 1'b0;
      rd_buf_sel  <= 1'b0;
      wr_buf_sel  <= 1'b0;
      result_buf  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        wtab[i] <= '0;
        btab[i] <= '0;
        atab[i] <= 1'b0;
      end
    end else begin
      eng_start <= 1'b0;
      done      <= 1'b0;
      // The engine itself keeps running after abort; only the sequencer unwinds.
      if (abort) begin
        state       <= S_IDLE;
        layer_idx   <= '0;
        busy        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cfg_we) begin
              wtab[cfg_addr] <= cfg_wbase;
              btab[cfg_addr] <= cfg_bbase;
              atab[cfg_addr] <= cfg_act;
            end
            if (cfg_nl_we) count <= nl_clamped;
            if (start && !eng_busy) begin
              if (count == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state      <= S_ISSUE;
                eng_start  <= 1'b1;
                busy       <= 1'b1;
                layer_idx  <= '0;
                w_base     <= wtab[0];
                b_base     <= btab[0];
                act_en     <= atab[0];
                rd_buf_sel <= 1'b0;
                wr_buf_sel <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            state <= S_RUN;
            wdog  <= '0;
          end
          S_RUN: begin
            wdog <= wdog_inc;
            if (eng_done) begin
              if (last_layer) begin
                result_buf <= wr_buf_sel;
                state      <= S_DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
              end else begin
                layer_idx  <= idx_nxt;
                w_base     <= wtab[idx_nxt];
                b_base     <= btab[idx_nxt];
                act_en     <= atab[idx_nxt];
                rd_buf_sel <= idx_nxt[0];
                wr_buf_sel <= ~idx_nxt[0];
                eng_start  <= 1'b1;
                state      <= S_ISSUE;
              end
            end else if (timeout_hit) begin
              state       <= S_ERR;
              timeout_err <= 1'b1;
              busy        <= 1'b0;
            end
          end
          S_DONE:  state <= S_IDLE;
          S_ERR:   state <= S_ERR;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer; a second instance with a short watchdog covers the error path.
module tb_conv_layer_sequencer;
  logic clk = 1'b0;
  logic rst_n, cfg_we, cfg_act, cfg_nl_we, start, abort, eng_busy, eng_done, t_eng_done;
  logic [1:0] cfg_addr;
  logic [11:0] cfg_wbase;
  logic [7:0] cfg_bbase;
  logic [2:0] cfg_nl;
  logic eng_start, act_en, rd_buf_sel, wr_buf_sel, result_buf, busy, done, timeout_err;
  logic [1:0] layer_idx;
  logic [11:0] w_base;
  logic [7:0] b_base;
  logic t_eng_start, t_act_en, t_rd, t_wr, t_result_buf, t_busy, t_done, t_timeout_err;
  logic [1:0] t_layer_idx;
  logic [11:0] t_w_base;
  logic [7:0] t_b_base;

  conv_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wbase(cfg_wbase),
    .cfg_bbase(cfg_bbase), .cfg_act(cfg_act), .cfg_nl_we(cfg_nl_we), .cfg_nl(cfg_nl),
    .start(start), .abort(abort), .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .layer_idx(layer_idx), .w_base(w_base), .b_base(b_base), .act_en(act_en),
    .rd_buf_sel(rd_buf_sel), .wr_buf_sel(wr_buf_sel), .result_buf(result_buf), .busy(busy),
    .done(done), .timeout_err(timeout_err));

  conv_layer_sequencer #(.TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wbase(cfg_wbase),
    .cfg_bbase(cfg_bbase), .cfg_act(cfg_act), .cfg_nl_we(cfg_nl_we), .cfg_nl(cfg_nl),
    .start(start), .abort(abort), .eng_start(t_eng_start), .eng_busy(eng_busy), .eng_done(t_eng_done),
    .layer_idx(t_layer_idx), .w_base(t_w_base), .b_base(t_b_base), .act_en(t_act_en),
    .rd_buf_sel(t_rd), .wr_buf_sel(t_wr), .result_buf(t_result_buf), .busy(t_busy),
    .done(t_done), .timeout_err(t_timeout_err));

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: descriptor table, clamped layer count, last completed result buffer.
  int ref_w [4];
  int ref_b [4];
  int ref_act [4];
  int ref_nl = 0;
  int ref_result = 0;

  // Engine model: done pulse eng_lat cycles after each observed start.
  bit eng_auto = 1'b1;
  int eng_lat = 20;
  int eng_cnt = 0;
  initial begin
    eng_busy = 1'b0;
    eng_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      eng_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin eng_done = 1'b1; eng_busy = 1'b0; end
      end
      if (eng_auto && eng_start) begin eng_cnt = eng_lat; eng_busy = 1'b1; end
    end
  end

  bit mon_en = 1'b0;
  int ev_start_cyc [$];
  logic [11:0] ev_w [$];
  logic [7:0] ev_b [$];
  logic ev_act [$];
  logic ev_rd [$];
  logic ev_wr [$];
  int ev_done_cyc [$];
  int busy_seen = 0;
  always @(negedge clk) if (mon_en) begin
    if (eng_start) begin
      ev_start_cyc.push_back(cyc); ev_w.push_back(w_base); ev_b.push_back(b_base);
      ev_act.push_back(act_en); ev_rd.push_back(rd_buf_sel); ev_wr.push_back(wr_buf_sel);
    end
    if (done) ev_done_cyc.push_back(cyc);
    if (busy) busy_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input int idx, input int w, input int b, input int act, input bit accept);
    cfg_we = 1'b1; cfg_addr = 2'(idx); cfg_wbase = 12'(w); cfg_bbase = 8'(b); cfg_act = 1'(act);
    tick(1);
    cfg_we = 1'b0;
    if (accept) begin ref_w[idx] = w; ref_b[idx] = b; ref_act[idx] = act; end
  endtask

  task automatic cfg_count(input int n, input bit accept);
    cfg_nl_we = 1'b1; cfg_nl = 3'(n);
    tick(1);
    cfg_nl_we = 1'b0;
    if (accept) ref_nl = (n > 4) ? 4 : n;
  endtask

  task automatic pulse_start(output int s);
    ev_start_cyc.delete(); ev_w.delete(); ev_b.delete(); ev_act.delete();
    ev_rd.delete(); ev_wr.delete(); ev_done_cyc.delete(); busy_seen = 0;
    mon_en = 1'b1;
    start = 1'b1;
    s = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick(1);
      if (ev_done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    tick(2);
    mon_en = 1'b0;
    if (ok && ref_nl > 0) ref_result = ((ref_nl - 1) % 2 == 0) ? 1 : 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    n_checks++;
    if ({eng_start, layer_idx, w_base, b_base, act_en, rd_buf_sel, wr_buf_sel, result_buf, busy, done, timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", {eng_start, layer_idx, w_base, b_base, act_en, rd_buf_sel, wr_buf_sel, result_buf, busy, done, timeout_err});
    end
    n_checks++;
    if ({t_eng_start, t_busy, t_done, t_timeout_err, t_result_buf} !== '0) begin
      n_fail++; $display("FAIL reset_outputs_to: got %b expected 0", {t_eng_start, t_busy, t_done, t_timeout_err, t_result_buf});
    end
    rst_n = 1'b1;
    tick(3);
    n_checks++;
    if ({eng_start, busy, done, timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got %b expected 0000", {eng_start, busy, done, timeout_err});
    end
  endtask

  task automatic test_layer_runs;
    for (int it = 0; it < 4; it++) begin
      int s, base;
      bit ok;
      logic [22:0] got, exp;
      if (it == 0) begin
        cfg_write(0, 'h000, 'h00, 1, 1);
        cfg_write(1, 'h030, 'h08, 1, 1);
        cfg_write(2, 'h090, 'h10, 0, 1);
        cfg_count(3, 1);
        eng_lat = 20;
      end else begin
        for (int k = 0; k < 4; k++)
          cfg_write(k, int'($urandom_range(0, 4095)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1);
        cfg_count((it == 3) ? 7 : int'($urandom_range(1, 4)), 1);
        eng_lat = int'($urandom_range(1, 25));
      end
      pulse_start(s);
      wait_done(600, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL run%0d_completes: no done seen, expected done", it); end
      n_checks++;
      if (ev_start_cyc.size() != ref_nl) begin
        n_fail++; $display("FAIL run%0d_start_count: got %0d expected %0d", it, ev_start_cyc.size(), ref_nl);
      end else begin
        for (int i = 0; i < ref_nl; i++) begin
          base = s + 1 + i * (eng_lat + 1);
          exp = {12'(ref_w[i]), 8'(ref_b[i]), 1'(ref_act[i]), 1'(i % 2), 1'(1 - i % 2)};
          got = {ev_w[i], ev_b[i], ev_act[i], ev_rd[i], ev_wr[i]};
          n_checks++;
          if (got !== exp || ev_start_cyc[i] != base) begin
            n_fail++; $display("FAIL run%0d_layer%0d: got fields %h at cycle %0d expected %h at cycle %0d", it, i, got, ev_start_cyc[i], exp, base);
          end
        end
      end
      n_checks++;
      if (ev_done_cyc.size() != 1 || ev_done_cyc[0] != s + 1 + ref_nl * (eng_lat + 1)) begin
        n_fail++; $display("FAIL run%0d_done: got %0d pulses first at %0d expected 1 at %0d", it, ev_done_cyc.size(),
                           (ev_done_cyc.size() > 0) ? ev_done_cyc[0] : -1, s + 1 + ref_nl * (eng_lat + 1));
      end
      n_checks++;
      if (result_buf !== 1'(ref_result)) begin
        n_fail++; $display("FAIL run%0d_result_buf: got %b expected %0d", it, result_buf, ref_result);
      end
    end
  endtask

  task automatic test_count_zero;
    int s;
    bit ok;
    cfg_count(0, 1);
    pulse_start(s);
    wait_done(20, ok);
    n_checks++;
    if (!ok || ev_done_cyc.size() != 1 || ev_done_cyc[0] != s + 1) begin
      n_fail++; $display("FAIL zero_done: got %0d pulses first at %0d expected 1 at %0d", ev_done_cyc.size(), ok ? ev_done_cyc[0] : -1, s + 1);
    end
    n_checks++;
    if (ev_start_cyc.size() != 0 || busy_seen != 0) begin
      n_fail++; $display("FAIL zero_no_engine: got %0d starts %0d busy cycles expected 0 and 0", ev_start_cyc.size(), busy_seen);
    end
  endtask

  task automatic test_cfg_lockout;
    int s;
    bit ok;
    cfg_write(0, 'h123, 'h45, 1, 1);
    cfg_count(2, 1);
    eng_lat = 10;
    pulse_start(s);
    tick(3);
    cfg_write(0, 'hFFF, 'hFF, 0, 0);
    cfg_count(1, 0);
    wait_done(200, ok);
    pulse_start(s);
    wait_done(200, ok);
    n_checks++;
    if (!ok || ev_start_cyc.size() != 2) begin
      n_fail++; $display("FAIL lockout_count: got %0d starts expected 2", ev_start_cyc.size());
    end
    n_checks++;
    if (ev_w.size() == 0 || ev_w[0] !== 12'(ref_w[0]) || ev_b[0] !== 8'(ref_b[0])) begin
      n_fail++; $display("FAIL lockout_wbase: got %h expected %h", (ev_w.size() > 0) ? ev_w[0] : 12'hxxx, 12'(ref_w[0]));
    end
  endtask

  task automatic test_abort;
    int s, nstart;
    bit ok;
    eng_lat = 20;
    cfg_count(3, 1);
    pulse_start(s);
    for (int k = 0; k < 80 && ev_start_cyc.size() < 2; k++) tick(1);
    tick(5);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_checks++;
    if ({busy, eng_start, done, layer_idx, result_buf} !== {5'b0, 1'(ref_result)}) begin
      n_fail++; $display("FAIL abort_idle: got busy/start/done/idx/res %b expected %b", {busy, eng_start, done, layer_idx, result_buf}, {5'b0, 1'(ref_result)});
    end
    nstart = ev_start_cyc.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 60 && eng_busy; k++) tick(1);
    tick(3);
    n_checks++;
    if (ev_start_cyc.size() != nstart || ev_done_cyc.size() != 0 || busy !== 1'b0 || eng_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_ignored: got %0d extra starts %0d done busy %b expected none", ev_start_cyc.size() - nstart, ev_done_cyc.size(), busy);
    end
    pulse_start(s);
    n_checks++;
    if (eng_start !== 1'b1 || layer_idx !== 2'd0 || w_base !== 12'(ref_w[0])) begin
      n_fail++; $display("FAIL abort_restart: got start %b idx %0d wbase %h expected 1 0 %h", eng_start, layer_idx, w_base, 12'(ref_w[0]));
    end
    wait_done(300, ok);
  endtask

  task automatic test_timeout;
    int s, te;
    bit held;
    eng_auto = 1'b0;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    cfg_count(2, 1);
    pulse_start(s);
    n_checks++;
    if (t_eng_start !== 1'b1) begin n_fail++; $display("FAIL wd_start: got %b expected 1", t_eng_start); end
    te = -1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (t_timeout_err) begin te = cyc; break; end
    end
    n_checks++;
    if (te != s + 1 + 16) begin n_fail++; $display("FAIL wd_fire_cycle: got %0d expected %0d", te, s + 17); end
    held = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      if (t_timeout_err !== 1'b1 || t_busy !== 1'b0 || t_eng_start !== 1'b0) held = 1'b0;
    end
    n_checks++;
    if (!held) begin n_fail++; $display("FAIL wd_sticky: got err %b busy %b expected 1 0", t_timeout_err, t_busy); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    n_checks++;
    if (t_timeout_err !== 1'b0 || t_busy !== 1'b0) begin
      n_fail++; $display("FAIL wd_abort_clear: got err %b busy %b expected 0 0", t_timeout_err, t_busy);
    end
    pulse_start(s);
    n_checks++;
    if (t_eng_start !== 1'b1) begin n_fail++; $display("FAIL wd_idle_after_abort: got start %b expected 1", t_eng_start); end
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    mon_en = 1'b0;
    eng_auto = 1'b1;
  endtask

  task automatic test_reset_mid_run;
    int s;
    bit ok;
    eng_lat = 20;
    cfg_count(3, 1);
    pulse_start(s);
    tick(8);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin ref_w[i] = 0; ref_b[i] = 0; ref_act[i] = 0; end
    ref_nl = 0;
    ref_result = 0;
    n_checks++;
    if ({eng_start, layer_idx, w_base, b_base, act_en, rd_buf_sel, wr_buf_sel, result_buf, busy, done, timeout_err} !== '0) begin
      n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", {eng_start, layer_idx, w_base, b_base, act_en, rd_buf_sel, wr_buf_sel, result_buf, busy, done, timeout_err});
    end
    for (int k = 0; k < 60 && eng_busy; k++) tick(1);
    pulse_start(s);
    wait_done(20, ok);
    n_checks++;
    if (!ok || ev_done_cyc[0] != s + 1 || ev_start_cyc.size() != 0) begin
      n_fail++; $display("FAIL midrun_count_cleared: got done at %0d with %0d starts expected %0d and 0", ok ? ev_done_cyc[0] : -1, ev_start_cyc.size(), s + 1);
    end
    cfg_count(1, 1);
    pulse_start(s);
    wait_done(100, ok);
    n_checks++;
    if (ev_w.size() != 1 || {ev_w[0], ev_b[0], ev_act[0]} !== 21'(0)) begin
      n_fail++; $display("FAIL midrun_desc_cleared: got %0d starts first desc %h expected 1 and 0", ev_w.size(), (ev_w.size() > 0) ? {ev_w[0], ev_b[0], ev_act[0]} : 21'h1fffff);
    end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wbase = '0; cfg_bbase = '0; cfg_act = 1'b0;
    cfg_nl_we = 1'b0; cfg_nl = '0; start = 1'b0; abort = 1'b0; t_eng_done = 1'b0;
    for (int i = 0; i < 4; i++) begin ref_w[i] = 0; ref_b[i] = 0; ref_act[i] = 0; end
    test_reset();
    test_layer_runs();
    test_count_zero();
    test_cfg_lockout();
    test_abort();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running, expected completion");
    $fatal(1, "time limit");
  end
endmodule
